pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the RISC core, successor to the plain load/increment PC.

---
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter sequencer with branch/jump, call/return via an
//             internal return-address stack, stall and sticky stack errors.
//  Option   : define PC_IRQ_EN to enable interrupt entry through the RAS.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    OFF_WIDTH    = 8,
  parameter int                    RAS_DEPTH    = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] IRQ_VECTOR   = DATA_WIDTH'(4)
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        stall,
  input  logic [2:0]                  op,
  input  logic                        take,
  input  logic [DATA_WIDTH-1:0]       target,
  input  logic [OFF_WIDTH-1:0]        offset,
  input  logic                        err_clr,
  input  logic                        irq,
  output logic [DATA_WIDTH-1:0]       pc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_full,
  output logic                        ras_empty,
  output logic                        ras_ovf,
  output logic                        ras_unf,
  output logic                        irq_ack
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [2:0] c_OP_HOLD   = 3'b000;
  localparam logic [2:0] c_OP_INC    = 3'b001;
  localparam logic [2:0] c_OP_JUMP   = 3'b010;
  localparam logic [2:0] c_OP_BRANCH = 3'b011;
  localparam logic [2:0] c_OP_CALL   = 3'b100;
  localparam logic [2:0] c_OP_RET    = 3'b101;

  localparam logic [DATA_WIDTH-1:0] c_PC_ONE  = DATA_WIDTH'(1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(RAS_DEPTH);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_ovf;
  logic                  r_unf;
  logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic                  w_full;
  logic                  w_empty;
  logic                  w_irq_take;
  logic                  w_irq_full;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_val;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [c_PTR_W-1:0]    w_wr_idx;
  logic [c_PTR_W-1:0]    w_top_idx;
  logic [DATA_WIDTH-1:0] w_offset_ext;

  assign w_full       = (r_cnt == c_CNT_MAX);
  assign w_empty      = (r_cnt == '0);
  assign w_wr_idx     = r_cnt[c_PTR_W-1:0];
  // Truncation maps count RAS_DEPTH onto the last slot as intended.
  assign w_top_idx    = c_PTR_W'(r_cnt - c_CNT_ONE);
  assign w_offset_ext = {{(DATA_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};

`ifdef PC_IRQ_EN
  logic r_irq_ack;

  assign w_irq_take = irq & ~w_full;
  assign w_irq_full = irq & w_full;
  assign irq_ack    = r_irq_ack;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_irq_ack <= 1'b0;
    else      r_irq_ack <= w_irq_take & ~stall;
  end
`else
  logic w_unused;

  assign w_irq_take = 1'b0;
  assign w_irq_full = 1'b0;
  assign irq_ack    = 1'b0;
  assign w_unused   = ^{irq, IRQ_VECTOR};
`endif

  always_comb begin
    w_pc_nxt   = r_pc;
    w_cnt_nxt  = r_cnt;
    w_push     = 1'b0;
    w_push_val = r_pc + c_PC_ONE;
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
    if (!stall) begin
      if (w_irq_take) begin
        // Interrupted op is dropped; the handler returns to this same pc.
        w_push     = 1'b1;
        w_push_val = r_pc;
        w_pc_nxt   = IRQ_VECTOR;
        w_cnt_nxt  = r_cnt + c_CNT_ONE;
      end else begin
        w_ovf_set = w_irq_full;
        case (op)
          c_OP_HOLD:   w_pc_nxt = r_pc;
          c_OP_INC:    w_pc_nxt = r_pc + c_PC_ONE;
          c_OP_JUMP:   w_pc_nxt = target;
          c_OP_BRANCH: w_pc_nxt = take ? (r_pc + w_offset_ext) : (r_pc + c_PC_ONE);
          c_OP_CALL: begin
            if (w_full) begin
              w_ovf_set = 1'b1;
            end else begin
              w_push    = 1'b1;
              w_pc_nxt  = target;
              w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
          end
          c_OP_RET: begin
            if (w_empty) begin
              w_unf_set = 1'b1;
            end else begin
              w_pc_nxt  = r_ras[w_top_idx];
              w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
          end
          default: w_pc_nxt = r_pc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pc  <= RESET_VECTOR;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_cnt <= w_cnt_nxt;
      // A set event wins over a simultaneous clear.
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_wr_idx] <= w_push_val;
  end

  assign pc        = r_pc;
  assign ras_count = r_cnt;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer (16-bit, RAS 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        take = 1'b0;
  logic [15:0] target = '0;
  logic [7:0]  offset = '0;
  logic        err_clr = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf, irq_ack;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JUMP = 3'b010,
                         BRANCH = 3'b011, CALL = 3'b100, RET = 3'b101;

  pc_sequencer dut (
    .clk(clk), .clr(clr), .stall(stall), .op(op), .take(take),
    .target(target), .offset(offset), .err_clr(err_clr), .irq(irq),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // Apply one op for one edge, then settle 1 time unit past it.
  task automatic step(input logic [2:0] o, input logic [15:0] tgt = 16'h0,
                      input logic [7:0] off = 8'h0, input logic tk = 1'b0);
    op = o; target = tgt; offset = off; take = tk;
    @(posedge clk); #1;
    op = HOLD; take = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    step(INC); step(INC);
    clr = 1'b0; #2;
    n_checks++;
    if ({pc, ras_count, ras_empty, ras_ovf, ras_unf, irq_ack} !== {16'h0000, 3'd0, 1'b1, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_state got pc=%h cnt=%0d e=%b o=%b u=%b a=%b", pc, ras_count, ras_empty, ras_ovf, ras_unf, irq_ack);
    end
    #2 clr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(INC);
      n_checks++;
      if (pc !== 16'(i)) begin
        n_errors++;
        $display("FAIL reset_inc%0d got %h exp %h", i, pc, 16'(i));
      end
    end
  endtask

  task automatic test_branch;
    step(JUMP, 16'h0010);
    step(BRANCH, 16'h0, 8'hF0, 1'b1);
    n_checks++;
    if (pc !== 16'h0000) begin n_errors++; $display("FAIL branch_back got %h exp 0000", pc); end
    step(BRANCH, 16'h0, 8'hF0, 1'b1);
    n_checks++;
    if (pc !== 16'hFFF0) begin n_errors++; $display("FAIL branch_wrap_down got %h exp fff0", pc); end
    step(JUMP, 16'hFFFF);
    step(INC);
    n_checks++;
    if (pc !== 16'h0000) begin n_errors++; $display("FAIL inc_wrap got %h exp 0000", pc); end
    step(JUMP, 16'hFFF8);
    step(BRANCH, 16'h0, 8'h10, 1'b1);
    n_checks++;
    if (pc !== 16'h0008) begin n_errors++; $display("FAIL branch_wrap_up got %h exp 0008", pc); end
    step(BRANCH, 16'h0, 8'h10, 1'b0);
    n_checks++;
    if (pc !== 16'h0009) begin n_errors++; $display("FAIL branch_not_taken got %h exp 0009", pc); end
  endtask

  task automatic test_call_ret;
    step(JUMP, 16'h0020);
    step(CALL, 16'h0100);
    n_checks++;
    if ({pc, ras_count} !== {16'h0100, 3'd1}) begin
      n_errors++; $display("FAIL call got pc=%h cnt=%0d exp 0100/1", pc, ras_count);
    end
    step(RET);
    n_checks++;
    if ({pc, ras_empty} !== {16'h0021, 1'b1}) begin
      n_errors++; $display("FAIL ret got pc=%h empty=%b exp 0021/1", pc, ras_empty);
    end
  endtask

  task automatic test_limits;
    logic [15:0] exp_ret [4] = '{16'h0501, 16'h0401, 16'h0301, 16'h0201};
    step(JUMP, 16'h0200);
    for (int i = 0; i < 4; i++) step(CALL, 16'h0300 + 16'(i) * 16'h0100);
    n_checks++;
    if ({pc, ras_count, ras_full, ras_ovf} !== {16'h0600, 3'd4, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL fill got pc=%h cnt=%0d full=%b ovf=%b", pc, ras_count, ras_full, ras_ovf);
    end
    step(CALL, 16'h0700);
    n_checks++;
    if ({pc, ras_count, ras_full, ras_ovf} !== {16'h0600, 3'd4, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL overflow got pc=%h cnt=%0d full=%b ovf=%b", pc, ras_count, ras_full, ras_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      step(RET);
      n_checks++;
      if (pc !== exp_ret[i]) begin n_errors++; $display("FAIL lifo%0d got %h exp %h", i, pc, exp_ret[i]); end
    end
    step(RET);
    n_checks++;
    if ({pc, ras_unf, ras_ovf, ras_empty} !== {16'h0201, 3'b111}) begin
      n_errors++; $display("FAIL underflow got pc=%h unf=%b ovf=%b empty=%b", pc, ras_unf, ras_ovf, ras_empty);
    end
    err_clr = 1'b1; step(RET); err_clr = 1'b0;
    n_checks++;
    if ({ras_ovf, ras_unf} !== 2'b01) begin
      n_errors++; $display("FAIL set_beats_clr got ovf=%b unf=%b exp 0/1", ras_ovf, ras_unf);
    end
    err_clr = 1'b1; step(HOLD); err_clr = 1'b0;
    n_checks++;
    if ({ras_ovf, ras_unf} !== 2'b00) begin
      n_errors++; $display("FAIL err_clr got ovf=%b unf=%b exp 0/0", ras_ovf, ras_unf);
    end
  endtask

  task automatic test_stall;
    step(JUMP, 16'h0040);
    step(RET);
    stall = 1'b1; err_clr = 1'b1;
    step(CALL, 16'h0800);
    stall = 1'b0; err_clr = 1'b0;
    n_checks++;
    if ({pc, ras_count, ras_unf} !== {16'h0040, 3'd0, 1'b0}) begin
      n_errors++; $display("FAIL stall_hold got pc=%h cnt=%0d unf=%b exp 0040/0/0", pc, ras_count, ras_unf);
    end
    step(CALL, 16'h0800);
    n_checks++;
    if ({pc, ras_count} !== {16'h0800, 3'd1}) begin
      n_errors++; $display("FAIL stall_release got pc=%h cnt=%0d exp 0800/1", pc, ras_count);
    end
  endtask

  task automatic test_back_to_back;
    step(RET);
    step(CALL, 16'h0A00);
    n_checks++;
    if ({pc, ras_count} !== {16'h0A00, 3'd1}) begin
      n_errors++; $display("FAIL ret_call got pc=%h cnt=%0d exp 0a00/1", pc, ras_count);
    end
    step(RET);
    n_checks++;
    if ({pc, ras_count} !== {16'h0042, 3'd0}) begin
      n_errors++; $display("FAIL ret_after_call got pc=%h cnt=%0d exp 0042/0", pc, ras_count);
    end
  endtask

  task automatic test_irq;
    step(JUMP, 16'h0030);
    irq = 1'b1; step(INC); irq = 1'b0;
`ifdef PC_IRQ_EN
    n_checks++;
    if ({pc, irq_ack, ras_count} !== {16'h0004, 1'b1, 3'd1}) begin
      n_errors++; $display("FAIL irq_take got pc=%h ack=%b cnt=%0d exp 0004/1/1", pc, irq_ack, ras_count);
    end
    step(HOLD);
    n_checks++;
    if (irq_ack !== 1'b0) begin n_errors++; $display("FAIL irq_ack_pulse got %b exp 0", irq_ack); end
    step(RET);
    n_checks++;
    if (pc !== 16'h0030) begin n_errors++; $display("FAIL irq_ret got %h exp 0030", pc); end
`else
    n_checks++;
    if ({pc, irq_ack, ras_count} !== {16'h0031, 1'b0, 3'd0}) begin
      n_errors++; $display("FAIL irq_ignored got pc=%h ack=%b cnt=%0d exp 0031/0/0", pc, irq_ack, ras_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_limits();
    test_stall();
    test_back_to_back();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
